// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_pkg
//  Brief    : Shared constants and entry type for the reorder buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int REG_ID_W          = 5;
    localparam int XLEN              = 32;
    localparam int DEFAULT_DEPTH_LOG = 3;

    // One in-flight instruction: allocated, result captured, destination.
    typedef struct packed {
        logic                valid;
        logic                done;
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     data;
    } rob_entry_t;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer_rob_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : rob_ptr
//  Brief    : Wrapping head/tail pointers plus occupancy counter.
//             inc advances tail (alloc), dec advances head (retire).
//  Revision : 1.0 - initial release
// ============================================================================
module rob_ptr
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = DEFAULT_DEPTH_LOG
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear,
    input  logic                 inc,
    input  logic                 dec,
    output logic [DEPTH_LOG-1:0] head,
    output logic [DEPTH_LOG-1:0] tail,
    output logic [DEPTH_LOG:0]   count
);

    localparam logic [DEPTH_LOG-1:0] C_PTR_ONE = DEPTH_LOG'(1);
    localparam logic [DEPTH_LOG:0]   C_CNT_ONE = (DEPTH_LOG + 1)'(1);

    // Pointer/counter bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (inc) tail <= tail + C_PTR_ONE;
            if (dec) head <= head + C_PTR_ONE;
            case ({inc, dec})
                2'b10:   count <= count + C_CNT_ONE;
                2'b01:   count <= count - C_CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule : rob_ptr
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Brief    : In-order retirement buffer feeding the register-file write port.
//             Allocates on issue, captures broadcast results, retires the
//             head entry once done; flush discards all speculative entries.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = DEFAULT_DEPTH_LOG
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_pipline,
    input  logic                 alloc_valid,
    input  logic [REG_ID_W-1:0]  alloc_rd,
    output logic                 alloc_ready,
    output logic [DEPTH_LOG-1:0] alloc_tag,
    input  logic                 wb_valid,
    input  logic [DEPTH_LOG-1:0] wb_tag,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 have_task,
    output logic [REG_ID_W-1:0]  reg_id,
    output logic                 rw,
    output logic [XLEN-1:0]      data_out,
    output logic [DEPTH_LOG:0]   count,
    output logic                 empty
);

    localparam int                 DEPTH   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] C_DEPTH = (DEPTH_LOG + 1)'(DEPTH);

    rob_entry_t            r_entries [DEPTH];
    logic [DEPTH_LOG-1:0]  w_head;
    logic [DEPTH_LOG-1:0]  w_tail;
    logic                  w_active;
    logic                  w_alloc_fire;
    logic                  w_wb_fire;
    logic                  w_commit;
    rob_entry_t            w_head_entry;

    // Flush overrides everything; otherwise rdy_in gates all state changes.
    assign w_active     = rdy_in && !flush_pipline;
    assign alloc_ready  = (count < C_DEPTH);
    assign alloc_tag    = w_tail;
    assign empty        = (count == '0);
    assign w_head_entry = r_entries[w_head];
    assign w_alloc_fire = w_active && alloc_valid && alloc_ready;
    // Validity is the pre-edge flag, so a same-cycle allocation is not hit.
    assign w_wb_fire    = w_active && wb_valid && r_entries[wb_tag].valid;
    assign w_commit     = w_active && w_head_entry.valid && w_head_entry.done;

    rob_ptr #(
        .DEPTH_LOG (DEPTH_LOG)
    ) u_rob_ptr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (flush_pipline),
        .inc    (w_alloc_fire),
        .dec    (w_commit),
        .head   (w_head),
        .tail   (w_tail),
        .count  (count)
    );

    // Entry storage: writeback, allocation and retirement of distinct slots.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
        end else if (flush_pipline) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].done  <= 1'b0;
            end
        end else begin
            if (w_wb_fire) begin
                r_entries[wb_tag].done <= 1'b1;
                r_entries[wb_tag].data <= wb_data;
            end
            if (w_alloc_fire) begin
                r_entries[w_tail].valid <= 1'b1;
                r_entries[w_tail].done  <= 1'b0;
                r_entries[w_tail].rd    <= alloc_rd;
            end
            // Retirement is last so it wins over a late writeback to the head.
            if (w_commit) begin
                r_entries[w_head].valid <= 1'b0;
                r_entries[w_head].done  <= 1'b0;
            end
        end
    end

    // Register-file write port: one pulse per retired entry, x0 is silent.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            have_task <= 1'b0;
            reg_id    <= '0;
            rw        <= 1'b0;
            data_out  <= '0;
        end else if (w_commit) begin
            have_task <= (w_head_entry.rd != '0);
            reg_id    <= w_head_entry.rd;
            rw        <= 1'b1;
            data_out  <= w_head_entry.data;
        end else begin
            have_task <= 1'b0;
        end
    end

endmodule : reorder_buffer
`default_nettype wire
